fetch_queue: RTL

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions in a DEPTH-entry FIFO and presents one {pc, instruction} pair per cycle to decode.
- Handles taken-branch redirects from the EX/MEM stage by flushing buffered and in-flight fetches.

---
 rtl/fetch_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem requests under a
// credit limit, and buffers returned {pc, inst} pairs for decode, with redirect flushing.
module fetch_queue #(
  parameter int unsigned     PC_W     = 64,
  parameter int unsigned     INST_W   = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rstPC,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_inst,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [PC_W-1:0]   if_pc
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthCnt = (CntW + 1)'(DEPTH);

  logic [PC_W-1:0]   fetchPcQ, fetchPcD;
  logic [CntW-1:0]   countQ, countD;
  logic [CntW-1:0]   inflightQ, inflightD;
  logic [CntW-1:0]   dropQ, dropD;
  logic [PtrW-1:0]   wrPtrQ, wrPtrD;
  logic [PtrW-1:0]   rdPtrQ, rdPtrD;
  logic [PC_W-1:0]   pcMem   [DEPTH];
  logic [INST_W-1:0] instMem [DEPTH];

  logic            reqFire;
  logic            push;
  logic            pop;
  logic [CntW:0]   occupied;
  logic [PC_W-1:0] rspPc;
  logic            unusedPcBits;

  assign unusedPcBits = ^redirect_pc[1:0];

  // Buffered entries plus outstanding requests never exceed DEPTH.
  assign occupied       = {1'b0, countQ} + {1'b0, inflightQ};
  assign imem_req_valid = rstPC & ~redirect & (occupied < DepthCnt);
  assign imem_req_addr  = fetchPcQ;
  assign reqFire        = imem_req_valid & imem_req_ready;

  // Live requests are consecutive words ending just below fetchPcQ, so the oldest one's
  // PC is recovered from the in-flight count rather than stored per request.
  assign rspPc = fetchPcQ - PC_W'({inflightQ, 2'b00});

  assign if_valid = (countQ != '0);
  assign if_inst  = if_valid ? instMem[rdPtrQ] : '0;
  assign if_pc    = if_valid ? pcMem[rdPtrQ] : '0;

  assign push = imem_rsp_valid & (dropQ == '0) & ~redirect;
  assign pop  = if_valid & id_ready & ~redirect;

  always_comb begin
    fetchPcD  = fetchPcQ;
    countD    = countQ;
    inflightD = inflightQ;
    dropD     = dropQ;
    wrPtrD    = wrPtrQ;
    rdPtrD    = rdPtrQ;
    if (redirect) begin
      fetchPcD  = {redirect_pc[PC_W-1:2], 2'b00};
      countD    = '0;
      wrPtrD    = '0;
      rdPtrD    = '0;
      inflightD = '0;
      // Every live request becomes stale; a response landing now retires one of them.
      dropD     = dropQ + inflightQ - CntW'(imem_rsp_valid);
    end else begin
      if (reqFire) begin
        fetchPcD = fetchPcQ + PC_W'(4);
      end
      inflightD = inflightQ + CntW'(reqFire) - CntW'(push);
      if (imem_rsp_valid && (dropQ != '0)) begin
        dropD = dropQ - CntW'(1);
      end
      countD = countQ + CntW'(push) - CntW'(pop);
      if (push) begin
        wrPtrD = wrPtrQ + PtrW'(1);
      end
      if (pop) begin
        rdPtrD = rdPtrQ + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstPC) begin
      fetchPcQ  <= RESET_PC;
      countQ    <= '0;
      inflightQ <= '0;
      dropQ     <= '0;
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
    end else begin
      fetchPcQ  <= fetchPcD;
      countQ    <= countD;
      inflightQ <= inflightD;
      dropQ     <= dropD;
      wrPtrQ    <= wrPtrD;
      rdPtrQ    <= rdPtrD;
    end
  end

  always_ff @(posedge clk) begin
    if (rstPC && push) begin
      pcMem[wrPtrQ]   <= rspPc;
      instMem[wrPtrQ] <= imem_rsp_inst;
    end
  end

endmodule
